seq_divider_rr: RTL and testbench
=================================

Name: seq_divider_rr

Overview:
Parametrised multi-cycle restoring (shift-subtract) integer divider built around a generalised remainder register. Produces quotient and remainder in WIDTH+1 cycles under a start/busy/done handshake. Supports optional signed mode and flags divide-by-zero and signed overflow. Sits beside the ALU as the iterative divide unit; it is a drop-in successor to the repeated-subtraction remainder register.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
SIGNED_EN, 1, 1 = signed_mode input honoured; 0 = signed_mode ignored, unsigned only

Ports:
clk  input  1  clock; all registers update on the falling edge
rst  input  1  synchronous active-high reset, sampled on the falling edge of clk
start  input  1  request; accepted only when busy=0
signed_mode  input  1  sampled with start; 1 = two's-complement operands
dividend  input  WIDTH  sampled with start
divisor  input  WIDTH  sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; results valid from this cycle on
quotient  output  WIDTH  result; held until the next accepted start completes
remainder  output  WIDTH  result; held as for quotient
dbz  output  1  divide-by-zero flag for the last result
ovf  output  1  signed overflow flag (MIN / -1) for the last result

Behaviour:
- Reset: state=IDLE; busy, done, dbz, ovf = 0; quotient, remainder = 0. rst overrides start and any operation in flight. No done pulse for an aborted operation.
- States: IDLE, RUN, FIXUP.
- IDLE with start=1 (edge 0): latch the sign flags. Load the magnitude of dividend into the quotient shift register and the magnitude of divisor into the divisor register. Clear the partial remainder (WIDTH+1 bits). Set the iteration counter to WIDTH. Go to RUN; busy=1.
- Divisor==0 at accept: no RUN. At edge 0, quotient=all ones, remainder=dividend (raw), dbz=1, ovf=0, done=1 for one cycle, busy stays 0.
- RUN, each edge: shift {R,Q} left by 1. Trial = R - divisor. If trial >= 0, R=trial and Q[0]=1; else R is restored and Q[0]=0. Decrement the counter. After the WIDTH-th iteration (edge WIDTH), go to FIXUP.
- FIXUP (edge WIDTH+1): quotient = -Q if the operand signs differ, else Q. remainder = -R if the dividend was negative, else R. Truncation is toward zero. dbz=0. ovf=1 iff signed and dividend=MIN and divisor=-1; quotient is then MIN and remainder 0. Set done=1 and busy=0. Return to IDLE.
- Latency: done is high in the cycle after edge WIDTH+1, for exactly one cycle.
- Unsigned mode, or SIGNED_EN=0: no magnitude conversion or fix-up negation, and ovf is always 0.
- start while busy: ignored; operands are not resampled.
- start in the cycle done=1 (state IDLE): accepted; back-to-back throughput is one result every WIDTH+1 edges.
- Outputs change only at FIXUP, at divide-by-zero accept, or at reset. They are stable while busy.
- Magnitude of MIN: computed in WIDTH+1 bits so that MIN/1 and MIN/-1 are exact before ovf detection.

Decomposition:
- Package div_pkg: state encoding (IDLE/RUN/FIXUP), counter width constant $clog2(WIDTH+1), and an abs/negate helper function.
- Sub-module rr_remainder_reg: the WIDTH+1-bit partial remainder plus the quotient shift register.
  - Controls: ld, clr, step.
  - Computes trial subtract/restore internally.
  - Exposes R and Q.
  - The controller FSM, sign handling and flags stay in the top module.

Test Plan:
- WIDTH=8, unsigned, 200/7 -> busy for 9 cycles; done pulse once; quotient=28, remainder=4, dbz=0, ovf=0.
- Signed: -7/2 -> quotient=0xFD (-3), remainder=0xFF (-1). 7/-2 -> 0xFD, 0x01. -8/-3 -> 0x02, 0xFE.
- Divide by zero: 55/0 -> done one cycle after accept; quotient=0xFF, remainder=55, dbz=1, busy never high.
- Signed overflow: -128/-1 -> quotient=0x80, remainder=0, ovf=1. Unsigned 128/255 -> quotient=0, remainder=128, ovf=0.
- Reset mid-op: start 100/3, rst on edge 4 -> busy=0, all outputs 0, no done pulse. Then 9/3 -> quotient=3, remainder=0.
- Handshake: start held high with new operands during RUN -> ignored, first result unaffected. start in the done cycle -> second result exactly WIDTH+1 edges later. Repeat with WIDTH=16: 65535/255 -> quotient=257, remainder=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } state_e;

    localparam int MAX_WIDTH = 64;

    typedef logic [MAX_WIDTH:0] wide_t;

    localparam wide_t WIDE_ONE = {{MAX_WIDTH{1'b0}}, 1'b1};

    function automatic int cnt_width(input int w);
        return $clog2(w + 32'sd1);
    endfunction

    // Two's-complement negate when neg is set; callers extend operands to WIDTH+1 bits or more.
    function automatic wide_t cond_negate(input wide_t v, input logic neg);
        wide_t res;
        if (neg) begin
            res = ~v + WIDE_ONE;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_divider_rr_if.sv
// Start/busy/done request bus of the iterative divider.
interface seq_divider_rr_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             dbz;
    logic             ovf;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  busy, done, quotient, remainder, dbz, ovf
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output busy, done, quotient, remainder, dbz, ovf
    );
endinterface

// File: rtl/rr_remainder_reg.sv
// Generalised remainder register: WIDTH+1-bit partial remainder and quotient
// shift register performing one restoring shift-subtract step per step_i.
module rr_remainder_reg
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_i,
    input  logic             clr_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   r_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0]   r_q;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH+1:0] trial_s;
    logic             fits_s;

    // Trial subtraction of the divisor from the shifted remainder; a clear sign bit means it fits.
    always_comb begin
        shift_s = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial_s = {1'b0, shift_s} - {2'b00, divisor_i};
        fits_s  = ~trial_s[WIDTH+1];
        r_d     = r_q;
        q_d     = q_q;
        if (clr_i) begin
            r_d = {(WIDTH+1){1'b0}};
        end else if (step_i) begin
            r_d = fits_s ? trial_s[WIDTH:0] : shift_s;
        end else begin
            r_d = r_q;
        end
        if (ld_i) begin
            q_d = dividend_i;
        end else if (step_i) begin
            q_d = {q_q[WIDTH-2:0], fits_s};
        end else begin
            q_d = q_q;
        end
    end

    // Remainder and quotient state, updated on the falling edge.
    always_ff @(negedge clk) begin
        if (rst) begin
            r_q <= {(WIDTH+1){1'b0}};
            q_q <= {WIDTH{1'b0}};
        end else begin
            r_q <= r_d;
            q_q <= q_d;
        end
    end

    assign r_o = r_q;
    assign q_o = q_q;

endmodule

// File: rtl/seq_divider_rr.sv
// Multi-cycle restoring integer divider with optional signed mode, divide-by-zero
// and MIN/-1 overflow flags; result after WIDTH+1 falling edges.
module seq_divider_rr
    import div_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    seq_divider_rr_if.slave bus
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam int             EXT      = MAX_WIDTH + 1 - WIDTH;
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvsr_q;
    logic             neg_quot_q;
    logic             neg_rem_q;
    logic             ovf_pend_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic             ovf_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;

    logic             signed_s;
    logic             dvd_neg_s;
    logic             dvs_neg_s;
    logic             accept_s;
    logic             zero_div_s;
    logic             ld_s;
    logic             step_s;
    logic             ovf_s;
    wide_t            dvd_wide_s;
    wide_t            dvs_wide_s;
    wide_t            quot_wide_s;
    wide_t            rem_wide_s;
    logic [WIDTH:0]   rr_r_s;
    logic [WIDTH-1:0] rr_q_s;
    logic             unused_s;

    // Operand decode: signedness, magnitudes (widened so MIN is exact) and sign fix-up of results.
    always_comb begin
        signed_s    = (SIGNED_EN != 1'b0) & bus.signed_mode;
        dvd_neg_s   = signed_s & bus.dividend[WIDTH-1];
        dvs_neg_s   = signed_s & bus.divisor[WIDTH-1];
        accept_s    = (state_q == IDLE) & bus.start;
        zero_div_s  = (bus.divisor == {WIDTH{1'b0}});
        ld_s        = accept_s & ~zero_div_s;
        step_s      = (state_q == RUN);
        ovf_s       = signed_s & (bus.dividend == MIN_VAL) & (bus.divisor == {WIDTH{1'b1}});
        dvd_wide_s  = cond_negate({{EXT{dvd_neg_s}}, bus.dividend}, dvd_neg_s);
        dvs_wide_s  = cond_negate({{EXT{dvs_neg_s}}, bus.divisor}, dvs_neg_s);
        quot_wide_s = cond_negate({{EXT{1'b0}}, rr_q_s}, neg_quot_q);
        rem_wide_s  = cond_negate({{EXT{1'b0}}, rr_r_s[WIDTH-1:0]}, neg_rem_q);
    end

    assign unused_s = ^{dvd_wide_s[MAX_WIDTH:WIDTH], dvs_wide_s[MAX_WIDTH:WIDTH],
                        quot_wide_s[MAX_WIDTH:WIDTH], rem_wide_s[MAX_WIDTH:WIDTH], rr_r_s[WIDTH]};

    rr_remainder_reg #(
        .WIDTH(WIDTH)
    ) u_rr (
        .clk        (clk),
        .rst        (rst),
        .ld_i       (ld_s),
        .clr_i      (ld_s),
        .step_i     (step_s),
        .dividend_i (dvd_wide_s[WIDTH-1:0]),
        .divisor_i  (dvsr_q),
        .r_o        (rr_r_s),
        .q_o        (rr_q_s)
    );

    // Controller FSM with registered handshake and result outputs.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= {CW{1'b0}};
            dvsr_q     <= {WIDTH{1'b0}};
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            quot_q     <= {WIDTH{1'b0}};
            rem_q      <= {WIDTH{1'b0}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_s && zero_div_s) begin
                        quot_q <= {WIDTH{1'b1}};
                        rem_q  <= bus.dividend;
                        dbz_q  <= 1'b1;
                        ovf_q  <= 1'b0;
                        done_q <= 1'b1;
                    end else if (accept_s) begin
                        dvsr_q     <= dvs_wide_s[WIDTH-1:0];
                        neg_quot_q <= dvd_neg_s ^ dvs_neg_s;
                        neg_rem_q  <= dvd_neg_s;
                        ovf_pend_q <= ovf_s;
                        cnt_q      <= CW'(WIDTH);
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= FIXUP;
                    end else begin
                        state_q <= RUN;
                    end
                end
                FIXUP: begin
                    // MIN/-1 needs no special path: the unnegated magnitude already reads as MIN.
                    quot_q  <= quot_wide_s[WIDTH-1:0];
                    rem_q   <= rem_wide_s[WIDTH-1:0];
                    dbz_q   <= 1'b0;
                    ovf_q   <= ovf_pend_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.dbz       = dbz_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_divider_rr.sv
// Scoreboard bench for seq_divider_rr at WIDTH=8 and WIDTH=16.
module tb_seq_divider_rr;

    logic clk;
    logic rst;

    seq_divider_rr_if #(.WIDTH(8))  bus8();
    seq_divider_rr_if #(.WIDTH(16)) bus16();

    seq_divider_rr #(.WIDTH(8),  .SIGNED_EN(1'b1)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
    seq_divider_rr #(.WIDTH(16), .SIGNED_EN(1'b1)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input longint a, input longint b, input bit sm, input int w);
        exp_t   e;
        longint mask;
        longint half;
        longint sa;
        longint sb;
        mask  = (longint'(1) << w) - 1;
        half  = longint'(1) << (w - 1);
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (b == 0) begin
            e.q   = 16'(mask);
            e.r   = 16'(a);
            e.dbz = 1'b1;
        end else if (sm) begin
            sa = (a >= half) ? a - (mask + 1) : a;
            sb = (b >= half) ? b - (mask + 1) : b;
            if (sa == -half && sb == -1) begin
                e.q   = 16'(half);
                e.r   = 16'h0000;
                e.ovf = 1'b1;
            end else begin
                e.q = 16'((sa / sb) & mask);
                e.r = 16'((sa % sb) & mask);
            end
        end else begin
            e.q = 16'(a / b);
            e.r = 16'(a % b);
        end
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
    endtask

    // Drive one start cycle and record the expected result.
    task automatic launch(input bit w16, input longint a, input longint b, input bit sm);
        if (w16) begin
            bus16.start = 1'b1; bus16.dividend = 16'(a); bus16.divisor = 16'(b); bus16.signed_mode = sm;
        end else begin
            bus8.start = 1'b1; bus8.dividend = 8'(a); bus8.divisor = 8'(b); bus8.signed_mode = sm;
        end
        sb_q.push_back(model(a, b, sm, w16 ? 16 : 8));
        cyc();
        bus8.start  = 1'b0;
        bus16.start = 1'b0;
    endtask

    task automatic wait_done(input bit w16, output int lat, output int busy_cyc, output bit got);
        lat = 0; busy_cyc = 0; got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if ((w16 ? bus16.done : bus8.done) === 1'b1) begin
                got = 1'b1;
                break;
            end
            if ((w16 ? bus16.busy : bus8.busy) === 1'b1) busy_cyc++;
            lat++;
            cyc();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        n_checks++;
        if ({bus8.busy, bus8.done, bus8.dbz, bus8.ovf} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {bus8.busy, bus8.done, bus8.dbz, bus8.ovf});
        else n_pass++;
        n_checks++;
        if ({bus8.quotient, bus8.remainder} !== 16'h0000) $display("FAIL reset_data: got %h expected 0000", {bus8.quotient, bus8.remainder});
        else n_pass++;
    endtask

    // Unsigned and signed operand tables: latency, busy length, result and single-cycle done.
    task automatic test_divide();
        logic [7:0] ta [12] = '{8'd200, 8'd7, 8'd128, 8'd255, 8'd9, 8'd3, 8'hF9, 8'h02, 8'h07, 8'hFE, 8'hF8, 8'hFD};
        logic [7:0] tb2[12] = '{8'h80, 8'hFF, 8'h80, 8'h01, 8'h7F, 8'hFF, 8'd255, 8'd1, 8'd0, 8'd9, 8'h81, 8'h03};
        bit   sm;
        int   lat, bc;
        bit   got;
        exp_t e;
        for (int k = 0; k < 12; k++) begin
            sm = (k >= 3 && k < 9);
            if (k < 6) launch(1'b0, longint'(ta[2*k]), longint'(ta[2*k+1]), sm);
            else       launch(1'b0, longint'(tb2[2*(k-6)]), longint'(tb2[2*(k-6)+1]), sm);
            wait_done(1'b0, lat, bc, got);
            e = sb_q.pop_front();
            n_checks++;
            if (!got || lat != 9 || bc != 9) $display("FAIL div_timing[%0d]: got done=%b lat=%0d busy=%0d expected done=1 lat=9 busy=9", k, got, lat, bc);
            else n_pass++;
            n_checks++;
            if ({bus8.quotient, bus8.remainder, bus8.dbz, bus8.ovf} !== {e.q[7:0], e.r[7:0], e.dbz, e.ovf})
                $display("FAIL div_result[%0d]: got q=%h r=%h dbz=%b ovf=%b expected q=%h r=%h dbz=%b ovf=%b",
                         k, bus8.quotient, bus8.remainder, bus8.dbz, bus8.ovf, e.q[7:0], e.r[7:0], e.dbz, e.ovf);
            else n_pass++;
            cyc();
            n_checks++;
            if (bus8.done !== 1'b0) $display("FAIL div_done_pulse[%0d]: got done=%b expected 0", k, bus8.done);
            else n_pass++;
        end
    endtask

    task automatic test_dbz();
        int   lat, bc;
        bit   got;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            launch(1'b0, (k == 0) ? 64'sd55 : 64'sd128, 64'sd0, k[0]);
            wait_done(1'b0, lat, bc, got);
            e = sb_q.pop_front();
            n_checks++;
            if (!got || lat != 0 || bc != 0 || bus8.busy !== 1'b0) $display("FAIL dbz_timing[%0d]: got done=%b lat=%0d busy=%0d expected done=1 lat=0 busy=0", k, got, lat, bc);
            else n_pass++;
            n_checks++;
            if ({bus8.quotient, bus8.remainder, bus8.dbz, bus8.ovf} !== {e.q[7:0], e.r[7:0], e.dbz, e.ovf})
                $display("FAIL dbz_result[%0d]: got q=%h r=%h dbz=%b ovf=%b expected q=%h r=%h dbz=%b ovf=%b",
                         k, bus8.quotient, bus8.remainder, bus8.dbz, bus8.ovf, e.q[7:0], e.r[7:0], e.dbz, e.ovf);
            else n_pass++;
            cyc();
            n_checks++;
            if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) $display("FAIL dbz_after[%0d]: got done=%b busy=%b expected 0 0", k, bus8.done, bus8.busy);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int   dones;
        int   lat, bc;
        bit   got;
        exp_t e;
        bus8.start = 1'b1; bus8.dividend = 8'd100; bus8.divisor = 8'd3; bus8.signed_mode = 1'b0;
        cyc();
        bus8.start = 1'b0;
        cyc(); cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_checks++;
        if ({bus8.busy, bus8.done, bus8.dbz, bus8.ovf, bus8.quotient, bus8.remainder} !== 20'h00000)
            $display("FAIL reset_mid_state: got busy=%b done=%b q=%h r=%h expected all zero", bus8.busy, bus8.done, bus8.quotient, bus8.remainder);
        else n_pass++;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus8.done === 1'b1) dones++;
            cyc();
        end
        n_checks++;
        if (dones != 0) $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", dones);
        else n_pass++;
        launch(1'b0, 64'sd9, 64'sd3, 1'b0);
        wait_done(1'b0, lat, bc, got);
        e = sb_q.pop_front();
        n_checks++;
        if (!got || {bus8.quotient, bus8.remainder} !== {e.q[7:0], e.r[7:0]})
            $display("FAIL reset_mid_next: got done=%b q=%h r=%h expected q=%h r=%h", got, bus8.quotient, bus8.remainder, e.q[7:0], e.r[7:0]);
        else n_pass++;
        cyc();
    endtask

    task automatic test_handshake();
        int   lat, bc;
        bit   got;
        exp_t e;
        launch(1'b0, 64'sd200, 64'sd7, 1'b0);
        bus8.start = 1'b1; bus8.dividend = 8'd13; bus8.divisor = 8'd5;
        for (int i = 0; i < 5; i++) cyc();
        bus8.start = 1'b0;
        wait_done(1'b0, lat, bc, got);
        e = sb_q.pop_front();
        n_checks++;
        if (!got || {bus8.quotient, bus8.remainder} !== {e.q[7:0], e.r[7:0]})
            $display("FAIL ignore_start: got done=%b q=%h r=%h expected q=%h r=%h", got, bus8.quotient, bus8.remainder, e.q[7:0], e.r[7:0]);
        else n_pass++;
        cyc();
        n_checks++;
        if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) $display("FAIL ignore_start_idle: got done=%b busy=%b expected 0 0", bus8.done, bus8.busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int   lat, bc;
        bit   got;
        exp_t e;
        launch(1'b0, 64'sd200, 64'sd7, 1'b0);
        wait_done(1'b0, lat, bc, got);
        e = sb_q.pop_front();
        n_checks++;
        if (!got || {bus8.quotient, bus8.remainder} !== {e.q[7:0], e.r[7:0]})
            $display("FAIL b2b_first: got done=%b q=%h r=%h expected q=%h r=%h", got, bus8.quotient, bus8.remainder, e.q[7:0], e.r[7:0]);
        else n_pass++;
        launch(1'b0, 64'sd249, 64'sd2, 1'b1);
        n_checks++;
        if (bus8.busy !== 1'b1 || {bus8.quotient, bus8.remainder} !== {e.q[7:0], e.r[7:0]})
            $display("FAIL b2b_hold: got busy=%b q=%h r=%h expected busy=1 q=%h r=%h", bus8.busy, bus8.quotient, bus8.remainder, e.q[7:0], e.r[7:0]);
        else n_pass++;
        wait_done(1'b0, lat, bc, got);
        e = sb_q.pop_front();
        n_checks++;
        if (!got || lat != 9 || {bus8.quotient, bus8.remainder} !== {e.q[7:0], e.r[7:0]})
            $display("FAIL b2b_second: got done=%b lat=%0d q=%h r=%h expected lat=9 q=%h r=%h", got, lat, bus8.quotient, bus8.remainder, e.q[7:0], e.r[7:0]);
        else n_pass++;
        cyc();
    endtask

    task automatic test_width16();
        int   lat, bc;
        bit   got;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) launch(1'b1, 64'sd65535, 64'sd255, 1'b0);
            else        launch(1'b1, 64'sd64536, 64'sd7, 1'b1);
            wait_done(1'b1, lat, bc, got);
            e = sb_q.pop_front();
            n_checks++;
            if (!got || lat != 17 || bc != 17) $display("FAIL w16_timing[%0d]: got done=%b lat=%0d busy=%0d expected done=1 lat=17 busy=17", k, got, lat, bc);
            else n_pass++;
            n_checks++;
            if ({bus16.quotient, bus16.remainder, bus16.dbz, bus16.ovf} !== {e.q, e.r, e.dbz, e.ovf})
                $display("FAIL w16_result[%0d]: got q=%h r=%h dbz=%b ovf=%b expected q=%h r=%h dbz=%b ovf=%b",
                         k, bus16.quotient, bus16.remainder, bus16.dbz, bus16.ovf, e.q, e.r, e.dbz, e.ovf);
            else n_pass++;
            cyc();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus8.start  = 1'b0; bus8.signed_mode  = 1'b0; bus8.dividend  = 8'h00;  bus8.divisor  = 8'h00;
        bus16.start = 1'b0; bus16.signed_mode = 1'b0; bus16.dividend = 16'h0000; bus16.divisor = 16'h0000;
        cyc();
        test_reset();
        test_divide();
        test_dbz();
        test_reset_mid();
        test_handshake();
        test_back_to_back();
        test_width16();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
